// File: rtl/mac_issue_ctrl.sv
// mac_issue_ctrl: operand-pair FIFO feeding a MAC with one operation outstanding at a time.
// Compile with `define MAC_ISSUE_TIMEOUT_EN to abort operations whose mac_done never arrives.
module mac_issue_ctrl #(
    parameter int FIFO_DEPTH   = 4,
    parameter int DONE_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        mac_valid,
    output logic [15:0] mac_a,
    output logic [15:0] mac_b,
    input  logic [31:0] mac_y,
    input  logic        mac_done,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        err_timeout
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DONE_TIMEOUT < 1) begin : g_bad_param
        $error("mac_issue_ctrl: FIFO_DEPTH must be a power of 2 >= 2 and DONE_TIMEOUT >= 1");
    end

    state_t        state_q, state_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [31:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   mac_a_q, mac_a_d;
    logic [15:0]   mac_b_q, mac_b_d;
    logic [31:0]   res_data_q, res_data_d;
    logic          push, pop, tmo_hit;

    // Fullness is judged on the registered count, so a pop never frees a slot in the same cycle.
    assign in_ready  = count_q != DEPTH_C;
    assign push      = in_valid && in_ready;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign mac_valid = state_q == S_ISSUE;
    assign res_valid = state_q == S_OUT;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign res_data  = res_data_q;

    // FIFO storage, pointers (wrap naturally at the power-of-2 depth) and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = {in_a, in_b};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    // Issue FSM: pop into the operand registers, pulse the MAC, wait for done, hold the result
    always_comb begin
        state_d    = state_q;
        mac_a_d    = mac_a_q;
        mac_b_d    = mac_b_q;
        res_data_d = res_data_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    {mac_a_d, mac_b_d} = mem_q[rd_ptr_q];
                    state_d            = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (mac_done) begin
                    res_data_d = mac_y;
                    state_d    = S_OUT;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_OUT: state_d = res_ready ? S_IDLE : S_OUT;
            default: state_d = S_IDLE;
        endcase
    end

    // Registers for the FIFO and the issue FSM; reset drops any queued or in-flight work
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            mac_a_q    <= '0;
            mac_b_q    <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mac_a_q    <= mac_a_d;
            mac_b_q    <= mac_b_d;
            res_data_q <= res_data_d;
        end
    end

`ifdef MAC_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(DONE_TIMEOUT + 1);
    localparam int TMO_LAST_I = DONE_TIMEOUT - 1;
    localparam logic [TW-1:0] TMO_LAST = TMO_LAST_I[TW-1:0];
    localparam logic [TW-1:0] TMO_ONE = 1;

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d;

    assign err_timeout = err_q;

    // Count cycles spent in WAIT; the last allowed cycle without mac_done aborts the operation
    always_comb begin
        tmo_hit   = (state_q == S_WAIT) && !mac_done && (tmo_cnt_q == TMO_LAST);
        tmo_cnt_d = (state_q == S_WAIT) ? tmo_cnt_q + TMO_ONE : '0;
        err_d     = err_q | tmo_hit;
    end

    // Timeout counter and the sticky error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mac_issue_ctrl.sv
// tb_mac_issue_ctrl: directed self-checking bench for mac_issue_ctrl with a hand-driven MAC.
module tb_mac_issue_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [31:0] mac_y = '0;
    logic        mac_done = 1'b0;
    logic        res_ready = 1'b0;
    logic        in_ready, mac_valid, res_valid, err_timeout;
    logic [15:0] mac_a, mac_b;
    logic [31:0] res_data;
    int checks = 0;
    int errors = 0;
    int issue_cnt = 0;
    int n_iss = 0;

    mac_issue_ctrl dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b),
        .mac_y(mac_y), .mac_done(mac_done), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // count issue pulses mid-cycle
    always @(negedge clk) if (mac_valid === 1'b1) issue_cnt <= issue_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int a, input int b);
        in_valid = 1'b1;
        in_a = a[15:0];
        in_b = b[15:0];
        chk("in_ready_push", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    // wait for the next issue, check held operands, return done after dly cycles, stall hold cycles
    task automatic do_op(input int a, input int b, input int y, input int dly, input int hold);
        n_iss++;
        for (int i = 0; i < 40 && issue_cnt < n_iss; i++) tick();
        chk("issue_seen", issue_cnt, n_iss);
        chk("mac_valid_one_cycle", mac_valid, 0);
        chk("mac_a", mac_a, a);
        chk("mac_b", mac_b, b);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("mac_a_held", mac_a, a);
            chk("mac_b_held", mac_b, b);
            chk("no_early_res", res_valid, 0);
        end
        mac_done = 1'b1;
        mac_y = y;
        tick();
        mac_done = 1'b0;
        mac_y = '0;
        chk("res_valid", res_valid, 1);
        chk("res_data", res_data, y);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("res_valid_hold", res_valid, 1);
            chk("res_data_hold", res_data, y);
            chk("no_issue_in_out", issue_cnt, n_iss);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_valid_drop", res_valid, 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mac_valid", mac_valid, 0);
        chk("rst_mac_a", mac_a, 0);
        chk("rst_mac_b", mac_b, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_err", err_timeout, 0);
        reset_n = 1'b1;
        tick();

        // single op, done three cycles after issue, two cycles of backpressure
        push(30, 40);
        do_op(30, 40, 1200, 3, 2);

        // back-to-back burst with an accumulating MAC
        push(10, 16);
        push(50, 25);
        push(100, 23);
        push(100, 24);
        do_op(10, 16, 160, 0, 0);
        do_op(50, 25, 1410, 0, 0);
        do_op(100, 23, 3710, 0, 0);
        do_op(100, 24, 6110, 0, 0);

        // fill the FIFO while the first op is stalled in WAIT
        push(1, 2);
        push(3, 4);
        push(5, 6);
        push(7, 8);
        push(9, 10);
        in_valid = 1'b1;
        in_a = 16'd11;
        in_b = 16'd12;
        chk("full_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_in_ready_stall", in_ready, 0);
        end
        do_op(1, 2, 2, 0, 0);
        chk("full_during_pop", in_ready, 0);
        tick();
        chk("ready_after_pop", in_ready, 1);
        tick();
        chk("full_after_5th", in_ready, 0);
        in_valid = 1'b0;
        do_op(3, 4, 12, 0, 0);
        do_op(5, 6, 30, 0, 0);
        do_op(7, 8, 56, 0, 0);
        do_op(9, 10, 90, 0, 0);
        do_op(11, 12, 132, 0, 0);

        // ten cycles of result backpressure with a second pair queued
        push(7, 8);
        push(9, 9);
        do_op(7, 8, 56, 0, 10);
        do_op(9, 9, 81, 0, 0);

        // mac_done never arrives
        push(3, 3);
        tick();
        chk("to_issue", mac_valid, 1);
        tick();
`ifdef MAC_ISSUE_TIMEOUT_EN
        n_iss++;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("to_err_early", err_timeout, 0);
            chk("to_no_res", res_valid, 0);
        end
        tick();
        chk("to_err_set", err_timeout, 1);
        chk("to_no_res_after", res_valid, 0);
        mac_done = 1'b1;
        mac_y = 32'd777;
        tick();
        mac_done = 1'b0;
        chk("late_done_ignored", res_valid, 0);
        push(4, 5);
        do_op(4, 5, 20, 0, 0);
        chk("to_err_sticky", err_timeout, 1);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("nto_err", err_timeout, 0);
            chk("nto_no_res", res_valid, 0);
        end
        do_op(3, 3, 9, 0, 0);
`endif

        // reset in WAIT with two pairs queued
        push(5, 5);
        push(6, 6);
        push(7, 7);
        tick();
        n_iss++;
        chk("mid_issued", issue_cnt, n_iss);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_mac_valid", mac_valid, 0);
        chk("mid_rst_mac_a", mac_a, 0);
        chk("mid_rst_mac_b", mac_b, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_res_data", res_data, 0);
        chk("mid_rst_err", err_timeout, 0);
        tick();
        reset_n = 1'b1;
        mac_done = 1'b1;
        mac_y = 32'd999;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_no_res", res_valid, 0);
            chk("post_rst_no_issue", issue_cnt, n_iss);
            chk("post_rst_ready", in_ready, 1);
        end
        mac_done = 1'b0;
        mac_y = '0;
        push(8, 9);
        do_op(8, 9, 72, 0, 0);
        tick();
        chk("final_issue_count", issue_cnt, n_iss);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
